// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Game-control stage that sits directly upstream of the 7-segment score
// display. One game is ROUNDS rounds long. Each round requests a new target
// colour (new_target pulse), then waits for either a debounced player press
// or a round timeout counted in `tick` pulses. A press while `match` is high
// scores a point (saturating at MAX_SCORE). After the last round game_over
// rises and the final score is held until the next start.
//
// Ports
//   clk          : system clock, all state on the rising edge
//   reset        : asynchronous active-low reset
//   start        : raw asynchronous start switch (game starts on its
//                  synchronized rising edge; not debounced)
//   btn          : raw asynchronous, bouncing player button
//   match        : synchronous level, player selection equals target;
//                  sampled on the press cycle
//   tick         : synchronous one-cycle round timebase enable
//   score        : current score 0..MAX_SCORE, feeds the display
//   new_target   : one-cycle request for a new target colour
//   round_active : high while waiting for a press or timeout
//   game_over    : high once all rounds are complete
//   round_num    : number of completed rounds in the current game
//   state_dbg    : current FSM state, exposed for debug and checkers
//
// Interface semantics: every output is a plain registered level or pulse.
// There is no backpressure anywhere; new_target is a fire-and-forget pulse
// that the colour generator must accept in the cycle it is asserted.
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int MAX_SCORE       = 16,
  parameter int ROUNDS          = 16,
  parameter int ROUND_TICKS     = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          btn,
  input  logic                          match,
  input  logic                          tick,
  output logic [4:0]                    score,
  output logic                          new_target,
  output logic                          round_active,
  output logic                          game_over,
  output logic [$clog2(ROUNDS+1)-1:0]   round_num,
  output logic [2:0]                    state_dbg
);

  // Counter widths sized so the terminal values always fit.
  localparam int RW = $clog2(ROUNDS + 1);
  localparam int TW = $clog2(ROUND_TICKS + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [4:0]    SCORE_MAX   = 5'(MAX_SCORE);
  localparam logic [RW-1:0] ROUND_LIMIT = RW'(ROUNDS);
  localparam logic [TW-1:0] TICK_LAST   = TW'(ROUND_TICKS - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Input synchronizers. start_prev holds the previous synchronized start
  // value so a rising edge can be formed without a third metastability stage.
  // ---------------------------------------------------------------------------
  logic btn_s1;
  logic btn_s2;
  logic start_s1;
  logic start_s2;
  logic start_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      btn_s1     <= btn;
      btn_s2     <= btn_s1;
      start_s1   <= start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
    end
  end

  logic start_edge;
  assign start_edge = start_s2 & ~start_prev;

  // ---------------------------------------------------------------------------
  // Button debounce. The counter measures how many consecutive cycles the
  // synchronized button has disagreed with the accepted level; any agreeing
  // sample restarts the count. The level flips on the DEBOUNCE_CYCLES-th
  // disagreeing sample, so shorter glitches never reach the FSM.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] db_cnt;
  logic          db_level;
  logic          db_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (btn_s2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= btn_s2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // One-cycle pulse on each accepted 0->1 transition of the button.
  logic press;
  assign press = db_level & ~db_prev;

  // ---------------------------------------------------------------------------
  // Game FSM. All outputs are registered: each output is set on the edge that
  // enters the state in which it must be visible, so they line up with
  // state_dbg without any combinational decode.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] round_inc;
  logic [4:0]    score_inc;

  assign round_inc = round_num + RW'(1);
  // Saturating increment: once at MAX_SCORE further hits are absorbed.
  assign score_inc = (score >= SCORE_MAX) ? SCORE_MAX : score + 5'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      score        <= '0;
      new_target   <= 1'b0;
      round_active <= 1'b0;
      game_over    <= 1'b0;
      round_num    <= '0;
      tick_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state      <= S_ARM;
            score      <= '0;
            round_num  <= '0;
            new_target <= 1'b1;
          end
        end

        S_ARM: begin
          // Single cycle: the new_target pulse is visible here, then the
          // round opens with a fresh tick budget.
          new_target   <= 1'b0;
          tick_cnt     <= '0;
          round_active <= 1'b1;
          state        <= S_WAIT;
        end

        S_WAIT: begin
          // A press is checked first so that a press landing on the same
          // cycle as the timeout tick is still scored.
          if (press) begin
            if (match) begin
              score <= score_inc;
            end
            round_active <= 1'b0;
            state        <= S_NEXT;
          end else if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              round_active <= 1'b0;
              state        <= S_NEXT;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        S_NEXT: begin
          round_num <= round_inc;
          if (round_inc == ROUND_LIMIT) begin
            game_over <= 1'b1;
            state     <= S_DONE;
          end else begin
            new_target <= 1'b1;
            state      <= S_ARM;
          end
        end

        S_DONE: begin
          // Final score and round count are held; presses and ticks have no
          // effect. A new start edge begins the next game directly.
          if (start_edge) begin
            game_over  <= 1'b0;
            score      <= '0;
            round_num  <= '0;
            new_target <= 1'b1;
            state      <= S_ARM;
          end
        end

        default: begin
          state        <= S_IDLE;
          new_target   <= 1'b0;
          round_active <= 1'b0;
          game_over    <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-control stage directly upstream of the 7-segment score display; produces the 5-bit `score` (0..16) that the display decodes.
- Runs one game of ROUNDS rounds. In each round it requests a new target colour, then waits for a debounced player press or a round timeout.
- Increments the score on a correct press.
- Asserts `game_over` after the last round and holds the final score until the next start.

Parameters:
- MAX_SCORE, 16: saturation value of `score`; must be ≤ 31.
- ROUNDS, 16: rounds per game.
- ROUND_TICKS, 3: `tick` pulses allowed per round before timeout.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a button level change. The bench uses 4; a board build uses a larger value.

Ports:
- clk, input, 1: system clock; all state is on its rising edge.
- reset, input, 1: asynchronous, active-low reset (asserted when 0); release is used as-is.
- start, input, 1: raw asynchronous start switch; a game starts on its synchronized rising edge.
- btn, input, 1: raw asynchronous, bouncing player button.
- match, input, 1: synchronous level, 1 when the player's current colour selection equals the target; sampled on the press-edge cycle.
- tick, input, 1: synchronous single-cycle enable from the clock divider (round timebase).
- score, output, 5: current score, 0..MAX_SCORE; feeds the display.
- new_target, output, 1: one-cycle pulse requesting the colour generator to pick a new target.
- round_active, output, 1: high while waiting for a press or timeout.
- game_over, output, 1: high in DONE.
- round_num, output, $clog2(ROUNDS+1): count of completed rounds.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: score=0, new_target=0, round_active=0, game_over=0, round_num=0.
  - Internal state: FSM=IDLE; synchronizers, debounce counter, debounced level and tick counter all cleared.
  - A reset mid-game aborts the game. No press or start is detected on the first cycle after release unless the synchronized level rises after release.
- Input conditioning:
  - btn and start each pass through a 2-FF synchronizer.
  - btn debounce: the counter increments each cycle the synchronized btn differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - press = one-cycle rising edge of the debounced level.
  - start_edge = one-cycle rising edge of the synchronized start; start is not debounced.
- FSM states: IDLE, ARM, WAIT, NEXT, DONE.
  - IDLE: outputs at reset values. On start_edge → ARM.
  - ARM (1 cycle): new_target=1, tick counter cleared → WAIT. On entry from IDLE or DONE, score and round_num clear to 0 on that same edge.
  - WAIT: round_active=1. Each tick increments the tick counter.
    - On press: if match=1, score ← min(score+1, MAX_SCORE); then → NEXT.
    - On timeout (tick arriving while the counter = ROUND_TICKS-1): → NEXT with score unchanged.
    - press and timeout in the same cycle: press wins and is scored normally.
  - NEXT (1 cycle): round_num+1. If the new value = ROUNDS → DONE, else → ARM.
  - DONE: game_over=1; score and round_num held. On start_edge → ARM (new game; game_over drops on that edge). press and tick are ignored.
- Event handling outside WAIT:
  - press in IDLE, ARM, NEXT or DONE is discarded, not queued.
  - start_edge outside IDLE and DONE is ignored.
- Arithmetic: score increments saturate at MAX_SCORE, with no wrap. round_num never exceeds ROUNDS.
- Latency:
  - Clean btn 0→1 held stable → press asserted 2 + DEBOUNCE_CYCLES + 1 cycles later (±1).
  - score updates on the edge following the press cycle.
  - new_target is asserted exactly 2 cycles after the press cycle (NEXT, then ARM).

Test Plan:
- Reset values: hold reset=0 with random inputs → all outputs 0. Release, idle 20 cycles → still 0, no new_target.
- Full-hit game, defaults: start rises, then 16 rounds of a clean btn press with match=1 → score steps 1..16, exactly 16 new_target pulses, game_over=1, round_num=16, score held at 16.
- Timeout and miss: round 1 press with match=0 and round 2 with no press for 3 ticks → score stays 0, round_num=2, third new_target pulse issued.
- Bounce filtering: btn high for 2 cycles, low 3, high 1, then stable high → exactly one press, score +1. Glitch-only input (≤3 cycles) → no score change.
- Saturation and collision (ROUNDS=20, MAX_SCORE=16):
  - All 20 rounds hit → score reaches 16 and holds through rounds 17..20; game_over=1 after round 20.
  - Separately, a press on the same cycle as the timeout tick with match=1 → score +1.
- Reset mid-game and restart: reset=0 during round 5 with score=4 → all outputs 0 immediately. In DONE, start toggled 0→1 → score=0, round_num=0, game_over=0, new_target pulse.
